// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asip_pkg
// Description : Shared types and constants for the decode-stage hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package asip_pkg;

    localparam int REG_ADDR_W  = 4;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  vf;
        logic [REG_ADDR_W-1:0] dest;
    } sb_entry_t;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : Decode-side and write-back signals of the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if;
    import asip_pkg::*;

    logic                   id_valid;
    logic                   id_wreg;
    logic                   id_vf;
    logic [REG_ADDR_W-1:0]  id_dest;
    logic [REG_ADDR_W-1:0]  id_src2;
    logic [REG_ADDR_W-1:0]  id_src3;
    logic [1:0]             id_src_en;
    logic [1:0]             id_muxR;
    logic                   flush;
    logic                   stall;
    logic                   issue;
    logic                   bubble;
    logic                   wb_valid;
    logic                   wb_vf;
    logic [REG_ADDR_W-1:0]  wb_dest;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_wreg, id_vf, id_dest, id_src2, id_src3,
               id_src_en, id_muxR, flush,
        input  stall, issue, bubble, wb_valid, wb_vf, wb_dest, stall_count
    );

    modport slave (
        input  id_valid, id_wreg, id_vf, id_dest, id_src2, id_src3,
               id_src_en, id_muxR, flush,
        output stall, issue, bubble, wb_valid, wb_vf, wb_dest, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_match.sv
`default_nettype none
// ============================================================================
// Module      : sb_match
// Description : Compares one scoreboard entry against one decoded source read.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_match
    import asip_pkg::*;
(
    input  sb_entry_t             i_entry,
    input  logic [REG_ADDR_W-1:0] i_src_addr,
    input  logic                  i_src_vf,
    input  logic                  i_src_en,
    output logic                  o_match
);

    // Register file select is part of the address: R5 and V5 never alias.
    assign o_match = i_src_en
                   & i_entry.valid
                   & (i_entry.vf   == i_src_vf)
                   & (i_entry.dest == i_src_addr);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode interlock tracking pending register writes up to write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import asip_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int WB_BYPASS   = 0,
    parameter int FLUSH_SLOTS = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_scoreboard_if.slave sb
);

    sb_entry_t              r_slots [DEPTH];
    sb_entry_t              w_next  [DEPTH];
    logic [DEPTH-1:0]       w_hit;
    logic                   w_hazard;
    logic                   w_stall;
    logic                   w_issue;
    logic [STALL_CNT_W-1:0] r_stall_count;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam bit c_IN_WINDOW = (gi < DEPTH - 1) || (WB_BYPASS == 0);
            logic w_m2;
            logic w_m3;

            sb_match u_match_src2 (
                .i_entry    (r_slots[gi]),
                .i_src_addr (sb.id_src2),
                .i_src_vf   (sb.id_muxR[1]),
                .i_src_en   (sb.id_src_en[1]),
                .o_match    (w_m2)
            );

            sb_match u_match_src3 (
                .i_entry    (r_slots[gi]),
                .i_src_addr (sb.id_src3),
                .i_src_vf   (sb.id_muxR[0]),
                .i_src_en   (sb.id_src_en[0]),
                .o_match    (w_m3)
            );

            assign w_hit[gi] = c_IN_WINDOW & (w_m2 | w_m3);
        end
    endgenerate

    // Reset suppresses stalls so decode can drain while nothing is recorded.
    assign w_hazard = sb.id_valid & (|w_hit) & ~rst;
    assign w_stall  = w_hazard & ~sb.flush;
    assign w_issue  = sb.id_valid & ~w_stall & ~sb.flush;

    assign sb.stall       = w_stall;
    assign sb.issue       = w_issue;
    assign sb.bubble      = ~w_issue;
    assign sb.wb_valid    = r_slots[DEPTH-1].valid;
    assign sb.wb_vf       = r_slots[DEPTH-1].vf;
    assign sb.wb_dest     = r_slots[DEPTH-1].dest;
    assign sb.stall_count = r_stall_count;

    // Entries sitting in the youngest FLUSH_SLOTS slots are killed as they shift.
    always_comb begin
        w_next[0] = '0;
        if (w_issue && sb.id_wreg) begin
            w_next[0] = {1'b1, sb.id_vf, sb.id_dest};
        end
        for (int i = 1; i < DEPTH; i++) begin
            w_next[i] = r_slots[i-1];
            if (sb.flush && ((i - 1) < FLUSH_SLOTS)) begin
                w_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
            r_stall_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= w_next[i];
            end
            if (w_stall) begin
                r_stall_count <= sat_inc(r_stall_count);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline interlock controller for the vector ASIP decode stage. It tracks every in-flight instruction that will write the scalar or vector register file, between issue from decode and write-back. When a decoding instruction reads a register that still has a pending write, it stalls decode and inserts a bubble into execute. It sits beside decode_module and consumes the decoded source/destination addresses, vector flags and the write-back handshake.

## Interface
Parameters:
- DEPTH, 3: stages between issue and register-file write (slot 0 = execute, slot DEPTH-1 = write-back).
- WB_BYPASS, 0: 1 = a write-back-slot entry does not cause a hazard (register file written before read in the same cycle); 0 = it does.
- FLUSH_SLOTS, 1: number of youngest slots invalidated by flush.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_wreg  in  1  instruction writes a register.
- id_vf  in  1  destination is in the vector file (1) or scalar file (0).
- id_dest  in  4  destination address.
- id_src2  in  4  first source address (post-immediate-mux address).
- id_src3  in  4  second source address.
- id_src_en  in  2  [1] = src2 is read, [0] = src3 is read.
- id_muxR  in  2  [1] = src2 is vector, [0] = src3 is vector.
- flush  in  1  taken jump, kill younger work.
- stall  out  1  hold fetch/decode this cycle.
- issue  out  1  decode instruction advances into execute.
- bubble  out  1  execute receives a NOP this cycle.
- wb_valid  out  1  the slot DEPTH-1 entry is valid; it qualifies the register write enable.
- wb_vf  out  1  vector flag of the write-back entry.
- wb_dest  out  4  destination of the write-back entry.
- stall_count  out  16  saturating count of stall cycles.

## Operation
- Scoreboard is a shift register of DEPTH entries {valid, vf, dest}. It shifts one slot every cycle unconditionally; the pipeline behind decode never stalls.
- Hazard on source k (k = 2, 3):
  - all of id_valid, id_src_en[k], an entry with valid = 1, entry.vf == id_muxR[k], and entry.dest == id_srck are true;
  - the slot index is < DEPTH-1, or WB_BYPASS = 0.
  - Scalar and vector address spaces are distinct: scalar R5 never hazards vector V5.
  - Address 0 is not exempt.
- stall = (hazard on src2 or src3) and not flush.
- issue = id_valid and not stall and not flush.
- bubble = not issue.
- Slot 0 next value:
  - {1, id_vf, id_dest} when issue and id_wreg;
  - otherwise valid = 0 (vf and dest are don't-care, but drive them to 0).
- Flush: slots 0..FLUSH_SLOTS-1 are invalidated at the next edge, after the shift. The decoded instruction is dropped and not recorded. Flush has priority over stall.
- stall_count increments on every cycle with stall = 1. It holds at 16'hFFFF.
- Hazards resolve on their own. A stalled instruction re-evaluates each cycle and issues once the matching entry passes the hazard window. Worst-case stall is DEPTH cycles (WB_BYPASS=0) or DEPTH-1 cycles (WB_BYPASS=1).

## Timing
- stall, issue, bubble: combinational from the current id_* inputs and the registered scoreboard. No registered latency.
- An instruction issued at edge N occupies slot 0 during cycle N+1 and slot DEPTH-1 during cycle N+DEPTH. wb_* are valid in that cycle.
- Reset:
  - all entries have valid = 0, vf = 0, dest = 0;
  - stall_count = 0;
  - wb_valid = 0, wb_vf = 0, wb_dest = 0.
  - While rst is high, stall = 0 and issue follows id_valid, but nothing is recorded.
- Reset mid-operation discards all pending writes. wb_valid is 0 from the next cycle.
- Simultaneous flush and hazard: flush wins, stall = 0, issue = 0.
- With DEPTH=3 and WB_BYPASS=0, back-to-back dependent instructions stall exactly 3 cycles.

## Structure
- Shared package (asip_pkg): sb_entry_t struct {valid, vf, dest[3:0]} and the REG_ADDR_W = 4 constant.
- One sub-module, sb_match: a combinational comparator taking one entry plus one source {addr, vf, en} and returning the match bit. It is instantiated 2×DEPTH times.
- The top level holds the shift register, the stall/issue logic and the counter.

## Test plan
- Independent stream: ADD R1, then ADD R2 reading R3/R4, every cycle → stall never asserts; wb_dest = 1 then 2 at cycles N+3 and N+4; stall_count = 0.
- RAW scalar: write R5, then next cycle read R5 via src2 (DEPTH=3, WB_BYPASS=0) → stall high for 3 cycles, issue on the 4th, stall_count = 3.
- Cross-file: write vector V5, then read scalar R5 (id_muxR=2'b00) → no stall; then read V5 with id_muxR[1]=1 → stall.
- WB_BYPASS=1 with the same RAW sequence → stall exactly 2 cycles.
- Flush: issue write R7, assert flush the next cycle while decode reads R7 → stall = 0, issue = 0, slot 0 invalidated, R7 entry never reaches wb_valid, next read of R7 issues immediately.
- Reset mid-flight: three pending writes, assert rst one cycle → wb_valid = 0 afterwards, stall_count = 0, a dependent read issues with no stall.
